alu_share_arb: RTL and testbench

- Arbitrates one shared ALU instance between two requesters: port 0 is the EX-stage issue path, port 1 is the branch/CSR helper path.
- Each request carries an op code and two already-selected 32-bit operands.
- The block captures the request, holds ALU inputs stable for the ALU's pipeline latency, then samples the result and zero flag.
- It returns the result to the granted requester through a valid/ready response handshake.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_share_arb_arb2_sel.sv | 13 +
 rtl/alu_share_arb.sv | 122 ++++++++++++
 tb/tb_alu_share_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op-code constants and the arbiter state encoding.
// Used by the shared-ALU arbiter, which has the optional feature macro ALU_SHARE_ARB_RR_EN.
package alu_pkg;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b1000;
    localparam logic [3:0] ALU_SLL     = 4'b0001;
    localparam logic [3:0] ALU_SLT     = 4'b0010;
    localparam logic [3:0] ALU_SLTU    = 4'b1010;
    localparam logic [3:0] ALU_XOR     = 4'b0100;
    localparam logic [3:0] ALU_SRL     = 4'b0101;
    localparam logic [3:0] ALU_SRA     = 4'b1101;
    localparam logic [3:0] ALU_OR      = 4'b0110;
    localparam logic [3:0] ALU_AND     = 4'b0111;
    localparam logic [3:0] ALU_LOADIMM = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic [1:0] onehot2(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_share_arb_arb2_sel.sv
// Combinational two-way winner select; on a tie the pointer input picks the winner.
// Tie the pointer to 0 for fixed priority toward requester 0.
module arb2_sel (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       any,
    output logic       win
);

    assign any = |req;
    assign win = (&req) ? ptr : ~req[0];

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between two requesters: capture, hold ALU inputs for ALU_LAT edges, return result.
// Define ALU_SHARE_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int W       = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [3:0]   req0_ctl,
    input  logic [3:0]   req1_ctl,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_zero,
    output logic [3:0]   alu_ctl,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_result,
    input  logic         alu_zero,
    output logic         busy,
    output logic         grant_id
);

    localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic          ptr;
    logic          any_req;
    logic          win_id;
    logic          req_hs;
    logic          rsp_hs;

`ifdef ALU_SHARE_ARB_RR_EN
    // The pointer prefers the requester that was not served last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (rsp_hs) begin
            ptr <= ~grant_id;
        end
    end
`else
    assign ptr = 1'b0;
`endif

    arb2_sel u_sel (
        .req (req_valid),
        .ptr (ptr),
        .any (any_req),
        .win (win_id)
    );

    assign req_ready = (rst_n && state == IDLE && any_req) ? onehot2(win_id) : 2'b00;
    assign req_hs    = |(req_valid & req_ready);
    assign rsp_hs    = (state == RESP) && rsp_ready[grant_id];
    assign rsp_valid = (rst_n && state == RESP) ? onehot2(grant_id) : 2'b00;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_hs) state_nxt = EXEC;
            EXEC:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ALU inputs only change on the request handshake, so they stay stable through EXEC and RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_ctl    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            grant_id   <= 1'b0;
            cnt        <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        alu_ctl  <= win_id ? req1_ctl : req0_ctl;
                        alu_a    <= win_id ? req1_a   : req0_a;
                        alu_b    <= win_id ? req1_b   : req0_b;
                        grant_id <= win_id;
                        cnt      <= CW'(ALU_LAT);
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: one instance with ALU_LAT=1 and one with ALU_LAT=0.
// Tie-break expectations follow ALU_SHARE_ARB_RR_EN.
module tb_alu_share_arb;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;

    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3:0]  req0_ctl, req1_ctl, alu_ctl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] rsp_result, alu_a, alu_b, alu_result;
    logic        rsp_zero, alu_zero, busy, grant_id;

    logic [1:0]  l0_req_valid, l0_req_ready, l0_rsp_valid, l0_rsp_ready;
    logic [3:0]  l0_req0_ctl, l0_req1_ctl, l0_alu_ctl;
    logic [31:0] l0_req0_a, l0_req0_b, l0_req1_a, l0_req1_b;
    logic [31:0] l0_rsp_result, l0_alu_a, l0_alu_b, l0_alu_result;
    logic        l0_rsp_zero, l0_alu_zero, l0_busy, l0_grant_id;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    logic [1:0]  tie2_grant_oh;
    logic        tie2_grant;
    logic [31:0] tie2_result;
    logic        tie2_zero;

    function automatic logic [31:0] aluf(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            ALU_ADD:     return a + b;
            ALU_SUB:     return a - b;
            ALU_SLL:     return a << b[4:0];
            ALU_SLT:     return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:    return {31'b0, a < b};
            ALU_XOR:     return a ^ b;
            ALU_SRL:     return a >> b[4:0];
            ALU_SRA:     return $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:      return a | b;
            ALU_AND:     return a & b;
            ALU_LOADIMM: return b;
            default:     return 32'h0;
        endcase
    endfunction

    // ALU model with one edge of latency for the main instance.
    always @(posedge clk) alu_result <= aluf(alu_ctl, alu_a, alu_b);
    assign alu_zero = (alu_result == 32'h0);

    assign l0_alu_result = aluf(l0_alu_ctl, l0_alu_a, l0_alu_b);
    assign l0_alu_zero   = (l0_alu_result == 32'h0);

    alu_share_arb #(.ALU_LAT(1), .W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_ctl(req0_ctl), .req1_ctl(req1_ctl),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .grant_id(grant_id)
    );

    alu_share_arb #(.ALU_LAT(0), .W(32)) dut_l0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(l0_req_valid), .req_ready(l0_req_ready),
        .req0_ctl(l0_req0_ctl), .req1_ctl(l0_req1_ctl),
        .req0_a(l0_req0_a), .req0_b(l0_req0_b), .req1_a(l0_req1_a), .req1_b(l0_req1_b),
        .rsp_valid(l0_rsp_valid), .rsp_ready(l0_rsp_ready),
        .rsp_result(l0_rsp_result), .rsp_zero(l0_rsp_zero),
        .alu_ctl(l0_alu_ctl), .alu_a(l0_alu_a), .alu_b(l0_alu_b),
        .alu_result(l0_alu_result), .alu_zero(l0_alu_zero),
        .busy(l0_busy), .grant_id(l0_grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] v,
                                 input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1);
        req_valid = v;
        req0_ctl  = c0;
        req0_a    = a0;
        req0_b    = b0;
        req1_ctl  = c1;
        req1_a    = a1;
        req1_b    = b1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) begin
            passed++;
        end else begin
            failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        rsp_ready    = 2'b00;
        l0_req_valid = 2'b00;
        l0_rsp_ready = 2'b00;
        l0_req0_ctl  = 4'h0;
        l0_req0_a    = 32'h0;
        l0_req0_b    = 32'h0;
        l0_req1_ctl  = 4'h0;
        l0_req1_a    = 32'h0;
        l0_req1_b    = 32'h0;
        applyStimulus(2'b11, ALU_ADD, 32'd1, 32'd2, ALU_ADD, 32'd3, 32'd4);

        // Reset held for two edges with both requests pending.
        cycle();
        cycle();
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_alu_ctl", 32'(alu_ctl), 32'h0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'h0);
        checkOutput("rst_rsp_result", rsp_result, 32'h0);

        // Single ADD on requester 0 with a slow response consumer.
        applyStimulus(2'b00, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0);
        rst_n = 1'b1;
        cycle();
        applyStimulus(2'b01, ALU_ADD, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0);
        checkOutput("add_req_ready", 32'(req_ready), 32'h1);
        cycle();
        checkOutput("add_busy", 32'(busy), 32'h1);
        checkOutput("add_grant", 32'(grant_id), 32'h0);
        checkOutput("add_alu_a", alu_a, 32'd5);
        checkOutput("add_alu_b", alu_b, 32'd7);
        checkOutput("add_alu_ctl", 32'(alu_ctl), 32'(ALU_ADD));
        checkOutput("add_ready_exec", 32'(req_ready), 32'h0);
        applyStimulus(2'b00, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0);
        cycle();
        checkOutput("add_exec2_rsp_valid", 32'(rsp_valid), 32'h0);
        cycle();
        checkOutput("add_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("add_rsp_result", rsp_result, 32'd12);
        checkOutput("add_rsp_zero", 32'(rsp_zero), 32'h0);
        rsp_ready = 2'b10;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkOutput("add_hold_valid", 32'(rsp_valid), 32'h1);
            checkOutput("add_hold_result", rsp_result, 32'd12);
        end
        rsp_ready = 2'b01;
        cycle();
        rsp_ready = 2'b00;
        checkOutput("add_done_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("add_done_busy", 32'(busy), 32'h0);

        // Two consecutive ties; a reset first returns the pointer to 0.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        applyStimulus(2'b11, ALU_SUB, 32'd9, 32'd9, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        checkOutput("tie1_req_ready", 32'(req_ready), 32'h1);
        cycle();
        checkOutput("tie1_grant", 32'(grant_id), 32'h0);
        cycle();
        cycle();
        checkOutput("tie1_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("tie1_rsp_result", rsp_result, 32'h0);
        checkOutput("tie1_rsp_zero", 32'(rsp_zero), 32'h1);
        rsp_ready = 2'b11;
        cycle();
        rsp_ready = 2'b00;
`ifdef ALU_SHARE_ARB_RR_EN
        tie2_grant_oh = 2'b10;
        tie2_grant    = 1'b1;
        tie2_result   = 32'd1;
        tie2_zero     = 1'b0;
`else
        tie2_grant_oh = 2'b01;
        tie2_grant    = 1'b0;
        tie2_result   = 32'd0;
        tie2_zero     = 1'b1;
`endif
        checkOutput("tie2_req_ready", 32'(req_ready), 32'(tie2_grant_oh));
        cycle();
        checkOutput("tie2_grant", 32'(grant_id), 32'(tie2_grant));
        cycle();
        cycle();
        checkOutput("tie2_rsp_valid", 32'(rsp_valid), 32'(tie2_grant_oh));
        checkOutput("tie2_rsp_result", rsp_result, tie2_result);
        checkOutput("tie2_rsp_zero", 32'(rsp_zero), 32'(tie2_zero));
        rsp_ready = 2'b11;
        applyStimulus(2'b00, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0);
        cycle();
        rsp_ready = 2'b00;
        checkOutput("tie2_done_busy", 32'(busy), 32'h0);

        // Combinational ALU instance: EXEC lasts one cycle.
        l0_req_valid = 2'b10;
        l0_req1_ctl  = ALU_SRA;
        l0_req1_a    = 32'h8000_0000;
        l0_req1_b    = 32'd4;
        #1;
        checkOutput("lat0_req_ready", 32'(l0_req_ready), 32'h2);
        cycle();
        l0_req_valid = 2'b00;
        checkOutput("lat0_exec_busy", 32'(l0_busy), 32'h1);
        checkOutput("lat0_exec_rsp_valid", 32'(l0_rsp_valid), 32'h0);
        cycle();
        checkOutput("lat0_rsp_valid", 32'(l0_rsp_valid), 32'h2);
        checkOutput("lat0_rsp_result", l0_rsp_result, 32'hF800_0000);
        l0_rsp_ready = 2'b10;
        cycle();
        l0_rsp_ready = 2'b00;
        checkOutput("lat0_done_busy", 32'(l0_busy), 32'h0);

        // Reset during the second EXEC cycle abandons the transaction.
        rsp_ready = 2'b11;
        applyStimulus(2'b01, ALU_ADD, 32'd20, 32'd22, ALU_ADD, 32'd0, 32'd0);
        cycle();
        applyStimulus(2'b00, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0);
        checkOutput("rstmid_exec1_busy", 32'(busy), 32'h1);
        cycle();
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_exec2_rsp_valid", 32'(rsp_valid), 32'h0);
        cycle();
        checkOutput("rstmid_busy", 32'(busy), 32'h0);
        checkOutput("rstmid_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rstmid_alu_a", alu_a, 32'h0);
        checkOutput("rstmid_rsp_result", rsp_result, 32'h0);
        rst_n = 1'b1;
        cycle();
        checkOutput("rstmid_after_rsp_valid", 32'(rsp_valid), 32'h0);
        rsp_ready = 2'b00;
        applyStimulus(2'b10, ALU_ADD, 32'd0, 32'd0, ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0);
        cycle();
        applyStimulus(2'b00, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0);
        checkOutput("post_rst_grant", 32'(grant_id), 32'h1);
        cycle();
        cycle();
        checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'h2);
        checkOutput("post_rst_result", rsp_result, 32'h0000_FF00);
        rsp_ready = 2'b10;
        cycle();
        rsp_ready = 2'b00;
        checkOutput("post_rst_done_busy", 32'(busy), 32'h0);

        // Requester 1 raises and drops valid while requester 0 owns the ALU.
        applyStimulus(2'b01, ALU_OR, 32'd3, 32'd4, ALU_AND, 32'd6, 32'd3);
        cycle();
        applyStimulus(2'b10, ALU_OR, 32'd3, 32'd4, ALU_AND, 32'd6, 32'd3);
        checkOutput("drop_req_ready_busy", 32'(req_ready), 32'h0);
        cycle();
        checkOutput("drop_rsp_valid_exec", 32'(rsp_valid), 32'h0);
        applyStimulus(2'b00, ALU_OR, 32'd3, 32'd4, ALU_AND, 32'd6, 32'd3);
        cycle();
        checkOutput("drop_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("drop_rsp_result", rsp_result, 32'd7);
        rsp_ready = 2'b01;
        cycle();
        rsp_ready = 2'b00;
        checkOutput("drop_idle_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkOutput("drop_no_txn_busy", 32'(busy), 32'h0);
            checkOutput("drop_no_rsp_valid", 32'(rsp_valid), 32'h0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
